// File: rtl/tt_sweep_driver.sv
// tt_sweep_driver: drives a 3-input truth-table gate through rows 000..111,
// waits a programmable settle time per row, captures the gate output into an
// 8-bit table (row 000 = MSB) and compares it against an expected table.
// Optional build macro: TT_MAJORITY_VOTE_EN -- sample each row three times
// and keep the majority value.
module tt_sweep_driver #(
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [7:0]          exp_tt,
  input  logic                gate_out,
  output logic                in1,
  output logic                in2,
  output logic                in3,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [7:0]          obs_tt,
  output logic [7:0]          mismatch
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t              state, state_nxt;
  logic [2:0]          row;
  logic [SETTLE_W-1:0] cnt;
  logic [SETTLE_W-1:0] cnt_rld;
  logic [SETTLE_W-1:0] eff_m1;
  logic [7:0]          exp_q;
  logic [7:0]          obs_nxt;
  logic                sample_bit;
  logic                sample_last;

  // A zero settle request behaves as one cycle; store S-1 for the down-counter.
  assign eff_m1 = (settle_cycles == '0) ? '0 : settle_cycles - SETTLE_W'(1);

`ifdef TT_MAJORITY_VOTE_EN
  logic [1:0] vote_idx;
  logic       vote0;
  logic       vote1;

  assign sample_last = (vote_idx == 2'd2);
  assign sample_bit  = (vote0 & vote1) | (vote0 & gate_out) | (vote1 & gate_out);

  // Collect the first two votes of the three-cycle sample window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_idx <= 2'd0;
      vote0    <= 1'b0;
      vote1    <= 1'b0;
    end else if (state == SAMPLE) begin
      if (vote_idx == 2'd0) vote0 <= gate_out;
      if (vote_idx == 2'd1) vote1 <= gate_out;
      vote_idx <= sample_last ? 2'd0 : vote_idx + 2'd1;
    end else begin
      vote_idx <= 2'd0;
    end
  end
`else
  assign sample_last = 1'b1;
  assign sample_bit  = gate_out;
`endif

  // Observed table with the current row's sample merged in.
  always_comb begin
    obs_nxt              = obs_tt;
    obs_nxt[3'd7 - row]  = sample_bit;
  end

  assign {in1, in2, in3} = row;
  assign mismatch        = obs_tt ^ exp_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = SETTLE;
      SETTLE: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        busy = 1'b1;
        if (sample_last) state_nxt = (row == 3'd7) ? DONE : SETTLE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Row stepping, settle counting, capture and verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row     <= 3'd0;
      cnt     <= '0;
      cnt_rld <= '0;
      exp_q   <= 8'h00;
      obs_tt  <= 8'h00;
      pass    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          row     <= 3'd0;
          cnt     <= eff_m1;
          cnt_rld <= eff_m1;
          exp_q   <= exp_tt;
          obs_tt  <= 8'h00;
          pass    <= 1'b0;
        end
        SETTLE: if (cnt != '0) cnt <= cnt - SETTLE_W'(1);
        SAMPLE: if (sample_last) begin
          obs_tt <= obs_nxt;
          if (row == 3'd7) begin
            pass <= (obs_nxt == exp_q);
          end else begin
            row <= row + 3'd1;
            cnt <= cnt_rld;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_driver.sv
// Bench for tt_sweep_driver: a behavioural gate model drives gate_out from a
// truth table; each sweep pushes its expected verdict and completion cycle
// into a scoreboard that a separate monitor pops whenever done is seen.
module tb_tt_sweep_driver;

`ifdef TT_MAJORITY_VOTE_EN
  localparam int M = 3;
`else
  localparam int M = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] settle_cycles = 8'd0;
  logic [7:0] exp_tt = 8'h00;
  logic       gate_out;
  logic       in1, in2, in3, busy, done, pass;
  logic [7:0] obs_tt, mismatch;

  tt_sweep_driver #(.SETTLE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .settle_cycles(settle_cycles),
    .exp_tt(exp_tt), .gate_out(gate_out), .in1(in1), .in2(in2), .in3(in3),
    .busy(busy), .done(done), .pass(pass), .obs_tt(obs_tt), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         dcyc;
    logic [7:0] obs;
    logic       pass;
    logic [7:0] mism;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  logic [7:0] gate_tt = 8'h00;
  logic       glitch_en = 1'b0;
  logic       trk = 1'b0;
  int         k = 0;
  int         cur_s = 1;
  logic       glitch;

  // Gate model: table lookup on the driven row, optionally glitched on the
  // first cycle of each sample window.
  always_comb begin
    glitch = 1'b0;
    if (glitch_en && trk && (cyc >= k) && (cyc - k < 8 * (cur_s + M)) &&
        ((cyc - k) % (cur_s + M) == cur_s))
      glitch = 1'b1;
  end
  assign gate_out = gate_tt[3'd7 - {in1, in2, in3}] ^ glitch;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rows"}, int'({in1, in2, in3}), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_obs"}, int'(obs_tt), 0);
    chk({tag, "_mismatch"}, int'(mismatch), 0);
  endtask

  // Monitor: row trace while busy, scoreboard pop on every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (trk && busy)
        chk("row_step", int'({in1, in2, in3}), ((cyc - k) / (cur_s + M)) % 8);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", cyc, e.dcyc);
          chk("obs_tt", int'(obs_tt), int'(e.obs));
          chk("pass", int'(pass), int'(e.pass));
          chk("mismatch", int'(mismatch), int'(e.mism));
          chk("rows_at_done", int'({in1, in2, in3}), 7);
        end
      end
    end
  end

  // One sweep. mode: 0 plain, 1 pulse start/change inputs mid-sweep,
  // 2 async reset while row 3 is driven.
  task automatic run_sweep(input logic [7:0] tt, input logic [7:0] ex,
                           input int s, input int mode);
    int   seff;
    int   budget;
    logic p2, p5;
    exp_t e;
    seff = (s == 0) ? 1 : s;
    p2 = 1'b0;
    p5 = 1'b0;
    @(negedge clk);
    gate_tt       = tt;
    exp_tt        = ex;
    settle_cycles = 8'(s);
    cur_s         = seff;
    start         = 1'b1;
    @(posedge clk);
    #1;
    k     = cyc;
    trk   = 1'b1;
    start = 1'b0;
    e.dcyc = k + 8 * (seff + M);
    e.obs  = tt;
    e.pass = (tt == ex);
    e.mism = tt ^ ex;
    sb.push_back(e);
    budget = 8 * (seff + M) + 10;
    for (int i = 0; i < budget && sb.size() != 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (mode == 1 && busy) begin
        if ({in1, in2, in3} == 3'd2 && !p2) begin
          p2 = 1'b1; start = 1'b1; exp_tt = ~ex; settle_cycles = 8'($urandom_range(0, 9));
        end
        if ({in1, in2, in3} == 3'd5 && !p5) begin
          p5 = 1'b1; start = 1'b1; exp_tt = 8'($urandom); settle_cycles = 8'd1;
        end
      end
      if (mode == 2 && busy && {in1, in2, in3} == 3'd3) begin
        #2;
        trk   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_busy", int'(busy), 0);
        return;
      end
    end
    start = 1'b0;
    chk("sweep_timeout", sb.size(), 0);
    sb.delete();
    trk = 1'b0;
  endtask

  initial begin
    // Reset held with start asserted.
    rst_n = 1'b0;
    start = 1'b1;
    exp_tt = 8'h59;
    settle_cycles = 8'd4;
    repeat (4) @(negedge clk);
    chk_zero_outputs("reset");
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero_outputs("post_release");

    run_sweep(8'h59, 8'h59, 4, 0);
    run_sweep(8'hFF, 8'h59, 4, 0);
    run_sweep(8'h59, 8'h59, 0, 0);
    run_sweep(8'h59, 8'h59, 1, 0);
    run_sweep(8'h59, 8'h59, 3, 2);
    run_sweep(8'h59, 8'h59, 4, 0);
    run_sweep(8'h59, 8'h59, 3, 1);

    for (int n = 0; n < 8; n++) begin
      logic [7:0] tt, ex;
      tt = 8'($urandom);
      ex = ($urandom_range(0, 1) == 0) ? tt : 8'($urandom);
      run_sweep(tt, ex, int'($urandom_range(0, 6)), 0);
    end

`ifdef TT_MAJORITY_VOTE_EN
    glitch_en = 1'b1;
    run_sweep(8'h59, 8'h59, 4, 0);
    run_sweep(8'hA3, 8'hA3, 2, 0);
    glitch_en = 1'b0;
`endif

    repeat (5) @(negedge clk);
    chk("idle_at_end", int'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
